// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the RV32I datapath and hazard_ctrl.
// The datapath side uses the master modport; the hazard sequencer uses slave.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              ex_is_load_i;
    logic [REG_AW-1:0] mem_rd_i;
    logic              mem_is_load_i;
    logic              ex_taken_i;
    logic              ext_stall_i;

    logic              pc_en_o;
    logic              pc_redirect_o;
    logic              ifid_en_o;
    logic              ifid_flush_o;
    logic              idex_en_o;
    logic              idex_flush_o;
    logic              exmem_en_o;
    logic              memwb_en_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_i, ex_is_load_i, mem_rd_i, mem_is_load_i,
        output ex_taken_i, ext_stall_i,
        input  pc_en_o, pc_redirect_o, ifid_en_o, ifid_flush_o,
        input  idex_en_o, idex_flush_o, exmem_en_o, memwb_en_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_i, ex_is_load_i, mem_rd_i, mem_is_load_i,
        input  ex_taken_i, ext_stall_i,
        output pc_en_o, pc_redirect_o, ifid_en_o, ifid_flush_o,
        output idex_en_o, idex_flush_o, exmem_en_o, memwb_en_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline-register sequencer: load-use stalls, redirect flush windows, memory-wait freeze.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int BR_FLUSH_CYC = 2,
    parameter int CNT_W        = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LSTALL = 2'd1;
    localparam logic [1:0] ST_BFLUSH = 2'd2;

    localparam logic [REG_AW-1:0] REG_ZERO  = '0;
    localparam logic [1:0]        FCNT_INIT = 2'(BR_FLUSH_CYC - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       hz_ex, hz_mem;

    // x0 is never a real producer, so rd==0 never raises a hazard.
    assign hz_ex = hz.ex_is_load_i && (hz.ex_rd_i != REG_ZERO) &&
                   ((hz.id_rs1_used_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                    (hz.id_rs2_used_i && (hz.id_rs2_i == hz.ex_rd_i)));
    assign hz_mem = hz.mem_is_load_i && (hz.mem_rd_i != REG_ZERO) &&
                    ((hz.id_rs1_used_i && (hz.id_rs1_i == hz.mem_rd_i)) ||
                     (hz.id_rs2_used_i && (hz.id_rs2_i == hz.mem_rd_i)));

    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        hz.pc_en_o       = 1'b1;
        hz.pc_redirect_o = 1'b0;
        hz.ifid_en_o     = 1'b1;
        hz.ifid_flush_o  = 1'b0;
        hz.idex_en_o     = 1'b1;
        hz.idex_flush_o  = 1'b0;
        hz.exmem_en_o    = 1'b1;
        hz.memwb_en_o    = 1'b1;
        if (!rst_ni) begin
            hz.pc_en_o      = 1'b0;
            hz.ifid_en_o    = 1'b0;
            hz.ifid_flush_o = 1'b1;
            hz.idex_en_o    = 1'b0;
            hz.idex_flush_o = 1'b1;
            hz.exmem_en_o   = 1'b0;
            hz.memwb_en_o   = 1'b0;
        end else if (hz.ext_stall_i) begin
            hz.pc_en_o    = 1'b0;
            hz.ifid_en_o  = 1'b0;
            hz.idex_en_o  = 1'b0;
            hz.exmem_en_o = 1'b0;
            hz.memwb_en_o = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz.ex_taken_i) begin
                        hz.pc_redirect_o = 1'b1;
                        hz.ifid_flush_o  = 1'b1;
                        hz.idex_flush_o  = 1'b1;
                        if (BR_FLUSH_CYC > 1) begin
                            fcnt_d  = FCNT_INIT;
                            state_d = ST_BFLUSH;
                        end
                    end else if (hz_ex || hz_mem) begin
                        hz.pc_en_o      = 1'b0;
                        hz.ifid_en_o    = 1'b0;
                        hz.idex_flush_o = 1'b1;
                        if (hz_ex) begin
                            state_d = ST_LSTALL;
                        end
                    end
                end
                ST_LSTALL: begin
                    hz.pc_en_o      = 1'b0;
                    hz.ifid_en_o    = 1'b0;
                    hz.idex_flush_o = 1'b1;
                    state_d         = ST_RUN;
                end
                ST_BFLUSH: begin
                    // The SRAM word arriving now was fetched down the wrong path.
                    hz.ifid_flush_o = 1'b1;
                    fcnt_d          = fcnt_q - 2'd1;
                    if (fcnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Stall freezing falls out of the next-state logic holding its value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             stall_evt, flush_evt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign stall_evt = !hz.ext_stall_i &&
                       ((state_q == ST_LSTALL) ||
                        ((state_q == ST_RUN) && !hz.ex_taken_i && (hz_ex || hz_mem)));
    assign flush_evt = !hz.ext_stall_i && (state_q == ST_RUN) && hz.ex_taken_i;

    // Saturating counters; they stop at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
`else
    assign hz.stall_cnt_o = {CNT_W{1'b0}};
    assign hz.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_hazard_ctrl;
    localparam logic [7:0] C_RST = 8'b0001_0100;
    localparam logic [7:0] C_RUN = 8'b1010_1011;
    localparam logic [7:0] C_STL = 8'b0000_1111;
    localparam logic [7:0] C_RED = 8'b1111_1111;
    localparam logic [7:0] C_BFL = 8'b1011_1011;
    localparam logic [7:0] C_FRZ = 8'b0000_0000;

    typedef struct {
        logic [7:0]  ctl;
        logic        chk_cnt;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   num_cmp;
    int   num_fail;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

    hazard_ctrl #(.REG_AW(5), .BR_FLUSH_CYC(2), .CNT_W(32)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .hz     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cnt(input int v);
`ifdef HAZARD_PERF_EN
        return 32'(v);
`else
        return (v == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [7:0] act;
        act = {bus.pc_en_o, bus.pc_redirect_o, bus.ifid_en_o, bus.ifid_flush_o,
               bus.idex_en_o, bus.idex_flush_o, bus.exmem_en_o, bus.memwb_en_o};
        num_cmp++;
        if (act !== e.ctl) begin
            num_fail++;
            $display("[TB] FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
        end
        if (e.chk_cnt) begin
            num_cmp++;
            if (bus.stall_cnt_o !== e.scnt) begin
                num_fail++;
                $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt_o, e.scnt);
            end
            num_cmp++;
            if (bus.flush_cnt_o !== e.fcnt) begin
                num_fail++;
                $display("[TB] FAIL %s flush_cnt: got %0d expected %0d", e.name, bus.flush_cnt_o, e.fcnt);
            end
        end
    endtask

    // Monitor: the outputs are combinational, so each cycle presents one result.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    task automatic applyStimulus(
        input string      name,
        input logic       rst,
        input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2,
        input logic [4:0] exrd, input logic exld,
        input logic [4:0] memrd, input logic memld,
        input logic       taken, input logic stall,
        input logic [7:0] ctl,
        input logic       chk, input int scnt, input int fcnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n             = rst;
        bus.id_rs1_i      = rs1;
        bus.id_rs1_used_i = u1;
        bus.id_rs2_i      = rs2;
        bus.id_rs2_used_i = u2;
        bus.ex_rd_i       = exrd;
        bus.ex_is_load_i  = exld;
        bus.mem_rd_i      = memrd;
        bus.mem_is_load_i = memld;
        bus.ex_taken_i    = taken;
        bus.ext_stall_i   = stall;
        e.ctl     = ctl;
        e.chk_cnt = chk;
        e.scnt    = cnt(scnt);
        e.fcnt    = cnt(fcnt);
        e.name    = name;
        sb.push_back(e);
    endtask

    task automatic idle(input string name, input logic [7:0] ctl, input logic chk,
                        input int scnt, input int fcnt);
        applyStimulus(name, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd4, 1'b0,
                      1'b0, 1'b0, ctl, chk, scnt, fcnt);
    endtask

    task automatic frozen(input string name);
        applyStimulus(name, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd4, 1'b0,
                      1'b0, 1'b1, C_FRZ, 1'b0, 0, 0);
    endtask

    initial begin
        num_cmp  = 0;
        num_fail = 0;
        rst_n    = 1'b0;
        bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_rs1_used_i = 1'b0; bus.id_rs2_used_i = 1'b0;
        bus.ex_rd_i = '0; bus.ex_is_load_i = 1'b0; bus.mem_rd_i = '0; bus.mem_is_load_i = 1'b0;
        bus.ex_taken_i = 1'b0; bus.ext_stall_i = 1'b0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus("reset", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, C_RST, 1'b1, 0, 0);
        end
        idle("first_run", C_RUN, 1'b1, 0, 0);

        // Load in EX feeding rs1: two bubbles.
        applyStimulus("lu_ex_c0", 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0,
                      1'b0, 1'b0, C_STL, 1'b0, 0, 0);
        applyStimulus("lu_ex_c1", 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1,
                      1'b0, 1'b0, C_STL, 1'b0, 0, 0);
        idle("lu_ex_c2", C_RUN, 1'b1, 2, 0);

        // Load in MEM feeding rs2: one bubble.
        applyStimulus("lu_mem_c0", 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 5'd7, 1'b1,
                      1'b0, 1'b0, C_STL, 1'b0, 0, 0);
        idle("lu_mem_c1", C_RUN, 1'b1, 3, 0);

        applyStimulus("ld_x0", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1,
                      1'b0, 1'b0, C_RUN, 1'b0, 0, 0);
        applyStimulus("rs1_unused", 1'b1, 5'd6, 1'b0, 5'd8, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0,
                      1'b0, 1'b0, C_RUN, 1'b0, 0, 0);

        // Taken branch: redirect, one BFLUSH cycle, normal.
        applyStimulus("br_c0", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd4, 1'b0,
                      1'b1, 1'b0, C_RED, 1'b0, 0, 0);
        idle("br_c1", C_BFL, 1'b0, 0, 0);
        idle("br_c2", C_RUN, 1'b1, 3, 1);

        // Redirect beats a simultaneous load-use hazard.
        applyStimulus("br_hz_c0", 1'b1, 5'd5, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0,
                      1'b1, 1'b0, C_RED, 1'b0, 0, 0);
        idle("br_hz_c1", C_BFL, 1'b0, 0, 0);
        idle("br_hz_c2", C_RUN, 1'b1, 3, 2);

        // Taken held under a memory wait is acted on once the wait drops.
        applyStimulus("pend_c0", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd4, 1'b0,
                      1'b1, 1'b1, C_FRZ, 1'b0, 0, 0);
        applyStimulus("pend_c1", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd4, 1'b0,
                      1'b1, 1'b0, C_RED, 1'b0, 0, 0);
        idle("pend_c2", C_BFL, 1'b0, 0, 0);
        idle("pend_c3", C_RUN, 1'b1, 3, 3);

        // Memory wait inside the BFLUSH window.
        applyStimulus("bfz_c0", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd4, 1'b0,
                      1'b1, 1'b0, C_RED, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) frozen("bfz_wait");
        idle("bfz_resume", C_BFL, 1'b0, 0, 0);
        idle("bfz_done", C_RUN, 1'b1, 3, 4);

        // Memory wait inside LSTALL.
        applyStimulus("lsz_c0", 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0,
                      1'b0, 1'b0, C_STL, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) frozen("lsz_wait");
        applyStimulus("lsz_resume", 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1,
                      1'b0, 1'b0, C_STL, 1'b0, 0, 0);
        idle("lsz_done", C_RUN, 1'b1, 5, 4);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            num_fail++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_fail);
        $finish;
    end
endmodule
